// File: rtl/bus_arbiter_2x1_pkg.sv
// Shared definitions for the two-requester round-robin bus arbiter:
// datapath width and the FSM state encoding.
package bus_arbiter_2x1_pkg;

    localparam int DATA_INDEX_LIMIT = 31;
    localparam int DATA_WIDTH_DEF   = DATA_INDEX_LIMIT + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_G0   = 2'b01,
        ST_G1   = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter_2x1_rr_pick_2.sv
// Combinational two-way round-robin picker. When both requesters are
// active the one that did not own the resource last wins.
module rr_pick_2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic vld_o,
    output logic winner_o
);

    // Requester 1 wins when it is alone or when requester 0 was served last.
    always_comb begin
        vld_o    = req0_i | req1_i;
        winner_o = req1_i & (~req0_i | ~last_i);
    end

endmodule

// File: rtl/bus_arbiter_2x1.sv
// Round-robin arbiter sharing one datapath port between two requesters,
// with REQ/GNT/DONE handshake and a hold timeout that forces release.
module bus_arbiter_2x1
    import bus_arbiter_2x1_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_HOLD   = 16,
    parameter int CNT_W      = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REQ0,
    input  logic                  REQ1,
    input  logic [DATA_WIDTH-1:0] DIN0,
    input  logic [DATA_WIDTH-1:0] DIN1,
    input  logic                  DONE,
    output logic                  GNT0,
    output logic                  GNT1,
    output logic                  SEL,
    output logic [DATA_WIDTH-1:0] DOUT,
    output logic                  BUSY,
    output logic                  TIMEOUT
);

    // Counter value seen on the last permitted grant cycle.
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
    localparam bit               HOLD_EN   = (MAX_HOLD != 0);

    arb_state_e       state_q, state_d;
    logic             last_q,  last_d;
    logic             sel_q,   sel_d;
    logic             gnt0_q,  gnt0_d;
    logic             gnt1_q,  gnt1_d;
    logic             tmo_q,   tmo_d;
    logic [CNT_W-1:0] hold_q,  hold_d;

    logic pick_vld;
    logic pick_win;
    logic own_req;
    logic expire;

    // The picker always sees LAST; at release LAST already equals the
    // releasing requester, so IDLE and release share one picker.
    rr_pick_2 u_pick (
        .req0_i   (REQ0),
        .req1_i   (REQ1),
        .last_i   (last_q),
        .vld_o    (pick_vld),
        .winner_o (pick_win)
    );

    // Next-state: arbitrate in IDLE, release/re-arbitrate or count in a grant.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        sel_d   = sel_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        hold_d  = hold_q;
        tmo_d   = 1'b0;
        own_req = (state_q == ST_G1) ? REQ1 : REQ0;
        expire  = HOLD_EN && (hold_q == HOLD_LAST) && !DONE;

        if (state_q == ST_IDLE || DONE || !own_req || expire) begin
            if (state_q != ST_IDLE) begin
                tmo_d = expire;
            end
            if (pick_vld) begin
                state_d = pick_win ? ST_G1 : ST_G0;
                last_d  = pick_win;
                sel_d   = pick_win;
                gnt0_d  = !pick_win;
                gnt1_d  = pick_win;
                hold_d  = '0;
            end else begin
                state_d = ST_IDLE;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
            end
        end else begin
            hold_d = hold_q + CNT_W'(1);
        end
    end

    // State and registered outputs; reset drops any grant immediately.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            sel_q   <= 1'b0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            hold_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            hold_q  <= hold_d;
            tmo_q   <= tmo_d;
        end
    end

    assign GNT0    = gnt0_q;
    assign GNT1    = gnt1_q;
    assign SEL     = sel_q;
    assign BUSY    = gnt0_q | gnt1_q;
    assign TIMEOUT = tmo_q;
    assign DOUT    = sel_q ? DIN1 : DIN0;

endmodule

// File: doc/bus_arbiter_2x1.md
Name: bus_arbiter_2x1

Overview:
Round-robin arbiter that shares one 32-bit datapath resource (e.g. a memory/bus port) between two requesters. It drives the select of a 32-bit 2:1 data mux and runs a REQ/GNT/DONE handshake with each requester. A hold-timeout counter forces release if the resource never signals completion. It sits between instruction-fetch/data-access masters and the shared port.

Parameters:
DATA_WIDTH, 32 (`DATA_INDEX_LIMIT+1), width of data inputs/output
MAX_HOLD, 16, max cycles one grant may last; 0 disables timeout
CNT_W, 8, hold-counter width; MAX_HOLD must fit in CNT_W bits

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  reset, asynchronous, active-low
REQ0  input  1  request from requester 0, level, held until DONE
REQ1  input  1  request from requester 1, level, held until DONE
DIN0  input  DATA_WIDTH  data from requester 0
DIN1  input  DATA_WIDTH  data from requester 1
DONE  input  1  one-cycle pulse from resource: current transaction complete
GNT0  output  1  registered grant to requester 0
GNT1  output  1  registered grant to requester 1
SEL  output  1  registered mux select, 0=DIN0, 1=DIN1
DOUT  output  DATA_WIDTH  SEL ? DIN1 : DIN0, combinational
BUSY  output  1  GNT0|GNT1
TIMEOUT  output  1  one-cycle pulse: grant revoked by hold timeout

Behaviour:
- Reset (RST=0, any time, async): state=IDLE, GNT0=GNT1=0, SEL=0, LAST=1 (requester 0 wins first tie), HOLD_CNT=0, TIMEOUT=0. DOUT follows DIN0. Reset mid-grant drops grant immediately; no DONE/TIMEOUT generated.
- States: IDLE, G0, G1. GNT0=1 iff G0, GNT1=1 iff G1; at most one grant ever.
- Arbitration (evaluated in IDLE, and at release in G0/G1): only REQ0 -> G0; only REQ1 -> G1; both -> requester != LAST; none -> IDLE.
- Latency: REQ seen at edge N in IDLE -> GNT/SEL valid after edge N (1 cycle). SEL updates same edge as GNT; in IDLE SEL holds last value.
- Entering Gx: LAST<=x, HOLD_CNT<=0.
- In Gx, each edge: release if any of (a) DONE=1, (b) REQx=0 (abort), (c) MAX_HOLD!=0 and HOLD_CNT==MAX_HOLD-1 and DONE=0. Otherwise HOLD_CNT++ and stay.
- On release: re-arbitrate same edge using current REQs with LAST=x, so the other requester, if requesting, gets back-to-back grant with no idle cycle; the releasing requester is re-granted only if the other is not requesting.
- Case (c) only: TIMEOUT=1 for exactly the following cycle. DONE and timeout on same cycle -> DONE wins, no TIMEOUT.
- DONE while IDLE: ignored.
- A grant never lasts more than MAX_HOLD cycles (MAX_HOLD!=0).
- HOLD_CNT saturates-free: never exceeds MAX_HOLD-1 when enabled; when MAX_HOLD=0 it wraps modulo 2^CNT_W, no effect.

Decomposition:
- Shared project definitions file: DATA_WIDTH / `DATA_INDEX_LIMIT, state encodings (IDLE=2'b00, G0=2'b01, G1=2'b10).
- Sub-module rr_pick_2: combinational round-robin picker (REQ0, REQ1, LAST -> grant-valid, winner). Reused for release and IDLE paths. Counter and FSM stay in top.

Test Plan:
- Reset: RST=0 with REQ0=REQ1=1 -> GNT0=GNT1=0, SEL=0, BUSY=0, TIMEOUT=0; DIN0='h00001234 -> DOUT='h00001234.
- Single request: REQ1=1 at cycle 0 -> GNT1=1, SEL=1 after 1 edge, DIN1='h12340000 -> DOUT='h12340000; DONE pulse -> GNT1=0, IDLE next cycle.
- Contention/fairness: REQ0=REQ1=1 from reset -> G0 first; DONE -> G1 next cycle with no idle gap; DONE -> G0; grants alternate for 4 transactions.
- Timeout: MAX_HOLD=4, REQ0=1, never DONE -> GNT0 high exactly 4 cycles, TIMEOUT=1 on 5th cycle only; with REQ1=1 pending, GNT1=1 on same edge GNT0 drops.
- DONE vs timeout same cycle: DONE on 4th grant cycle -> release, TIMEOUT stays 0; abort: REQ0 drops mid-grant -> GNT0=0 next edge, TIMEOUT=0.
- Async reset mid-grant: RST low between edges while GNT1=1 -> GNT1=0, SEL=0 immediately; after release, REQ1=REQ0=1 -> G0 first.
